half_band_filter_param: RTL and testbench
=========================================

Name: half_band_filter_param

Overview:
- Parametrised, pipelined half-band FIR, successor to the fixed 2-pair half-band stage in the DDC chain.
- Adds:
  - generic data/coefficient widths and symmetric-pair count K;
  - runtime-writable coefficients;
  - input valid qualification;
  - optional decimate-by-2 mode;
  - rounding and output saturation.
- Sits between the CIC/mixer output and the next decimation stage.

Parameters:
- DATA_W, 18, sample width (signed, in and out)
- COEF_W, 18, coefficient width (signed, value = coef / 2^COEF_W)
- K, 2, number of non-zero symmetric coefficient pairs. Tap count N = 4K-1; centre tap index C = 2K-1.
- COEF_INIT, {18'sd-12940, 18'sd77324}, K*COEF_W packed reset coefficients. Index 0 (LSBs) is the innermost pair.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  x_in is a new sample this cycle
- x_in  in  DATA_W  signed input sample
- decim_en  in  1  1 = emit every second sample; 0 = full rate
- coef_we  in  1  coefficient write strobe
- coef_addr  in  max(1,clog2(K))  coefficient index, 0 = innermost
- coef_wdata  in  COEF_W  signed coefficient value
- out_valid  out  1  y holds a new result this cycle
- y  out  DATA_W  signed filtered output

Behaviour:
- Reset (reset=0, async):
  - delay line x[0..N-1] cleared to 0;
  - pipeline valid flags cleared;
  - decimation phase cleared to 0;
  - coef[] loaded from COEF_INIT;
  - y=0, out_valid=0.
  - Takes effect mid-operation: any in-flight samples are discarded.
- Input stage (edge k, in_valid=1):
  - x[0] <= x_in >>> 1 (arithmetic prescale by 1/2).
  - x[i] <= x[i-1] for i=1..N-1.
  - With in_valid=0 the delay line holds.
- Stage B (edge k+1), for j=0..K-1:
  - p[j] <= (x[C-(2j+1)] + x[C+(2j+1)]) * coef[j].
  - Pre-add is DATA_W+1 bits; product is DATA_W+1+COEF_W bits.
  - Centre term c <= x[C] >>> 1 (fixed coefficient 0.5).
  - Valid flag vB <= (stage A accepted this edge) AND emit, where:
    - emit = 1 if decim_en=0;
    - emit = phase if decim_en=1 (phase evaluated before its toggle).
- Decimation phase:
  - Toggles on every accepted sample while decim_en=1.
  - Forced to 0 while decim_en=0.
  - The first accepted sample after reset, or after decim_en rises, is therefore dropped; the second is emitted.
- Stage C (edge k+2):
  - acc = sum_j ((p[j] + 2^(COEF_W-1)) >>> COEF_W) + c. This is round-half-up per product.
  - Accumulator width is DATA_W+clog2(K)+2.
  - y <= saturate(acc) to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_valid <= vB.
  - y updates only when vB=1 and otherwise holds its last value.
- Latency:
  - The result for the sample accepted at edge k appears on y, with out_valid=1, in the cycle after edge k+2.
  - Throughput is 1 sample/cycle; back-to-back in_valid is supported and gaps are allowed.
- Coefficient write:
  - On edge with coef_we=1 and coef_addr<K: coef[coef_addr] <= coef_wdata.
  - coef_addr>=K: write ignored.
  - A new value is first used by stage B at the following edge. A write in the same cycle as in_valid affects the product computed one edge later, never the current edge.
  - Delay line and pipeline are not flushed by writes.
- decim_en changes mid-stream take effect for the next accepted sample. Samples already in flight are unaffected.

Test Plan:
- Impulse, default coefs, decim_en=0:
  - Stimulus: x_in=65536 for one valid sample, then zeros (continuous in_valid).
  - Required: out_valid every cycle; y = -1617, 0, 9666, 16384, 9666, 0, -1617, then 0. First value in the cycle after edge k+2.
- Decimation, decim_en=1:
  - Impulse on the 1st accepted sample after reset: emitted y = 0, 16384, 0, 0.
  - Impulse on the 2nd accepted sample: emitted y = -1617, 9666, 9666, -1617.
  - In both cases out_valid is high on every other accepted sample only.
- Saturation:
  - Write coef[0]=coef[1]=131071.
  - Constant x_in=131071 for 10 samples: y settles at 131071.
  - Constant x_in=-131072: y settles at -131072.
- Gapped input:
  - Impulse test with in_valid alternating 1/0.
  - Required: same y sequence as the first test; out_valid pulses exactly 2 edges after each accepted sample; y holds between pulses.
- Coefficient write:
  - Write coef[1]=0 mid-stream; an impulse injected after the write shows the ±1617 outer taps as 0.
  - A write with coef_addr=K (for K a power of two, use K=3) leaves all coefs unchanged.
- Reset:
  - Assert reset low asynchronously during the impulse response.
  - Required: y=0 and out_valid=0 immediately; after release, zero input gives y=0 and coefs are back to COEF_INIT.

Source files
------------

// File: rtl/half_band_filter_param.sv
// Parametrised pipelined half-band FIR with prescale, optional decimate-by-2,
// runtime coefficients, per-product rounding and output saturation.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   in_valid   : x_in carries a new sample this cycle
//   x_in       : signed input sample (DATA_W)
//   decim_en   : 1 = emit every second accepted sample, 0 = full rate
//   coef_we    : coefficient write strobe
//   coef_addr  : coefficient index, 0 = innermost pair
//   coef_wdata : signed coefficient value (COEF_W, scaled by 2^-COEF_W)
//   out_valid  : y holds a new result this cycle
//   y          : signed saturated output (DATA_W)
module half_band_filter_param #(
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int K      = 2,
    parameter logic [K*COEF_W-1:0] COEF_INIT = {-18'sd12940, 18'sd77324}
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic signed [DATA_W-1:0]            x_in,
    input  logic                                decim_en,
    input  logic                                coef_we,
    input  logic [((K>1)?$clog2(K):1)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]            coef_wdata,
    output logic                                out_valid,
    output logic signed [DATA_W-1:0]            y
);

    localparam int N     = 4*K - 1;
    localparam int C     = 2*K - 1;
    localparam int AW    = (K > 1) ? $clog2(K) : 1;
    localparam int PRE_W = DATA_W + 1;
    localparam int PW    = DATA_W + 1 + COEF_W;
    localparam int ACC_W = DATA_W + $clog2(K) + 2;

    // Half an LSB of the Q(COEF_W) product, for round-half-up.
    localparam logic signed [PW:0] RND =
        {{(PW-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] r_x    [N];
    logic signed [COEF_W-1:0] r_coef [K];
    logic signed [PW-1:0]     r_p    [K];
    logic signed [DATA_W-1:0] r_c;
    logic                     r_phase;
    logic                     r_va;
    logic                     r_vb;
    logic                     r_ov;
    logic signed [DATA_W-1:0] r_y;

    logic signed [PRE_W-1:0]  w_pre  [K];
    logic signed [PW:0]       w_rnd;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [DATA_W-1:0] w_sat;
    logic                     w_emit;

    // Phase is sampled before it toggles, so the first accepted sample
    // after reset or after decim_en rises is dropped.
    assign w_emit = decim_en ? r_phase : 1'b1;

    // Stage A: prescaled delay line, advances only on accepted samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) r_x[i] <= '0;
            r_va    <= 1'b0;
            r_phase <= 1'b0;
        end else begin
            r_va <= in_valid & w_emit;
            if (!decim_en)     r_phase <= 1'b0;
            else if (in_valid) r_phase <= ~r_phase;
            if (in_valid) begin
                r_x[0] <= x_in >>> 1;
                for (int i = 1; i < N; i++) r_x[i] <= r_x[i-1];
            end
        end
    end

    // Out-of-range addresses match no index and are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < K; j++)
                r_coef[j] <= COEF_INIT[j*COEF_W +: COEF_W];
        end else begin
            for (int j = 0; j < K; j++)
                if (coef_we && coef_addr == AW'(j))
                    r_coef[j] <= coef_wdata;
        end
    end

    always_comb begin
        for (int j = 0; j < K; j++)
            w_pre[j] = PRE_W'(r_x[C-(2*j+1)]) + PRE_W'(r_x[C+(2*j+1)]);
    end

    // Stage B: symmetric pre-add, multiply, centre tap at fixed 0.5.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < K; j++) r_p[j] <= '0;
            r_c  <= '0;
            r_vb <= 1'b0;
        end else begin
            for (int j = 0; j < K; j++)
                r_p[j] <= PW'(w_pre[j]) * PW'(r_coef[j]);
            r_c  <= r_x[C] >>> 1;
            r_vb <= r_va;
        end
    end

    always_comb begin
        w_acc = ACC_W'(r_c);
        w_rnd = '0;
        for (int j = 0; j < K; j++) begin
            w_rnd = ((PW+1)'(r_p[j]) + RND) >>> COEF_W;
            w_acc = w_acc + ACC_W'(w_rnd);
        end
    end

    always_comb begin
        w_sat = w_acc[DATA_W-1:0];
        if (w_acc > SAT_HI)      w_sat = SAT_HI[DATA_W-1:0];
        else if (w_acc < SAT_LO) w_sat = SAT_LO[DATA_W-1:0];
    end

    // Stage C: y holds its last value when no result is due.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y  <= '0;
            r_ov <= 1'b0;
        end else begin
            r_ov <= r_vb;
            if (r_vb) r_y <= w_sat;
        end
    end

    assign y         = r_y;
    assign out_valid = r_ov;

endmodule

// File: tb/tb_half_band_filter_param.sv
// Bench for half_band_filter_param: K=2 default and K=3 instances driven
// together, compared every cycle against a convolution reference model.
module tb_half_band_filter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                in_valid;
    logic signed [17:0]  x_in;
    logic                decim_en;
    logic                we0, we1;
    logic [0:0]          addr0;
    logic [1:0]          addr1;
    logic signed [17:0]  wd;
    logic                ov0, ov1;
    logic signed [17:0]  y0, y1;

    half_band_filter_param u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .decim_en(decim_en), .coef_we(we0), .coef_addr(addr0),
        .coef_wdata(wd), .out_valid(ov0), .y(y0)
    );

    half_band_filter_param #(
        .K(3),
        .COEF_INIT({-18'sd3000, 18'sd20000, 18'sd70000})
    ) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in),
        .decim_en(decim_en), .coef_we(we1), .coef_addr(addr1),
        .coef_wdata(wd), .out_valid(ov1), .y(y1)
    );

    int     total = 0;
    int     bad   = 0;
    longint mx [2][11];
    longint mc [2][3];
    bit     ph [2];
    bit     sv0 [2], sv1 [2], ev [2];
    longint sy0 [2], sy1 [2], ey [2];
    longint cap0 [$];
    longint cap1 [$];
    longint exp_q [$];

    function automatic longint fir(int ch);
        int kk, cc;
        longint acc, p;
        kk  = (ch == 1) ? 3 : 2;
        cc  = 2*kk - 1;
        acc = mx[ch][cc] >>> 1;
        for (int j = 0; j < kk; j++) begin
            p   = (mx[ch][cc-2*j-1] + mx[ch][cc+2*j+1]) * mc[ch][j];
            acc = acc + ((p + 131072) >>> 18);
        end
        if (acc > 131071)  acc = 131071;
        if (acc < -131072) acc = -131072;
        return acc;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < 11; i++) mx[ch][i] = 0;
            ph[ch] = 0; sv0[ch] = 0; sv1[ch] = 0; ev[ch] = 0;
            sy0[ch] = 0; sy1[ch] = 0; ey[ch] = 0;
        end
        mc[0][0] = 77324; mc[0][1] = -12940; mc[0][2] = 0;
        mc[1][0] = 70000; mc[1][1] = 20000;  mc[1][2] = -3000;
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < 2; ch++) begin
            int kk, n;
            bit emit;
            kk = (ch == 1) ? 3 : 2;
            n  = 4*kk - 1;
            ev[ch] = sv1[ch];
            if (sv1[ch]) ey[ch] = sy1[ch];
            sv1[ch] = sv0[ch];
            sy1[ch] = sy0[ch];
            sv0[ch] = 0;
            if (ch == 0 && we0) mc[0][addr0] = wd;
            if (ch == 1 && we1 && addr1 < 3) mc[1][addr1] = wd;
            if (in_valid) begin
                for (int i = n-1; i > 0; i--) mx[ch][i] = mx[ch][i-1];
                mx[ch][0] = longint'(x_in) >>> 1;
                emit = decim_en ? ph[ch] : 1'b1;
                if (emit) begin
                    sv0[ch] = 1;
                    sy0[ch] = fir(ch);
                end
            end
            if (!decim_en)     ph[ch] = 0;
            else if (in_valid) ph[ch] = ~ph[ch];
        end
    endtask

    task automatic chk(input string tag, input longint got, input longint expv);
        total++;
        assert (got === expv)
        else begin
            bad++;
            $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, expv);
        end
    endtask

    task automatic check();
        chk("ov_k2", longint'(ov0), longint'(ev[0]));
        chk("y_k2",  longint'(y0),  ey[0]);
        chk("ov_k3", longint'(ov1), longint'(ev[1]));
        chk("y_k3",  longint'(y1),  ey[1]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check();
        if (ov0 === 1'b1) cap0.push_back(longint'(y0));
        if (ov1 === 1'b1) cap1.push_back(longint'(y1));
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic wr(input int ch, input int a, input int v);
        if (ch == 0) begin we0 = 1'b1; addr0 = 1'(a); end
        else         begin we1 = 1'b1; addr1 = 2'(a); end
        wd = 18'(v);
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; x_in = '0;
        we0 = 1'b0; we1 = 1'b0;
        #1;
        model_reset();
        check();
        @(posedge clk);
        #1;
        check();
        reset = 1'b1;
    endtask

    task automatic run_imp(input bit d, input bit gap, input int pre,
                           input int tot, input bit rst);
        decim_en = d;
        if (rst) do_reset();
        in_valid = 1'b0; x_in = '0;
        repeat (3) step();
        cap0.delete();
        cap1.delete();
        for (int i = 0; i < tot; i++) begin
            in_valid = 1'b1;
            x_in = (i == pre) ? 18'sd65536 : 18'sd0;
            step();
            if (gap) begin
                in_valid = 1'b0; x_in = '0;
                step();
            end
        end
        in_valid = 1'b0; x_in = '0;
        repeat (3) step();
    endtask

    task automatic cmp_seq(input string tag, input longint got[$]);
        chk({tag, "_len"}, longint'(got.size()), longint'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; x_in = '0; decim_en = 1'b0;
        we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wd = '0;

        // Impulse at full rate
        run_imp(0, 0, 0, 8, 1);
        exp_q = '{-1617, 0, 9666, 16384, 9666, 0, -1617, 0};
        cmp_seq("imp", cap0);
        exp_q = '{-375, 0, 2500, 0, 8750, 16384, 8750, 0};
        cmp_seq("imp_k3", cap1);

        // Decimation, impulse on 1st then 2nd accepted sample
        run_imp(1, 0, 0, 9, 1);
        exp_q = '{0, 16384, 0, 0};
        cmp_seq("dec1", cap0);
        run_imp(1, 0, 1, 9, 1);
        exp_q = '{-1617, 9666, 9666, -1617};
        cmp_seq("dec2", cap0);

        // Gapped input
        run_imp(0, 1, 0, 8, 1);
        exp_q = '{-1617, 0, 9666, 16384, 9666, 0, -1617, 0};
        cmp_seq("gap", cap0);

        // Saturation both directions
        decim_en = 1'b0;
        do_reset();
        wr(0, 0, 131071); step();
        wr(0, 1, 131071); step();
        in_valid = 1'b1;
        x_in = 18'sd131071;
        repeat (12) step();
        chk("sat_hi", longint'(y0), 131071);
        x_in = 18'(-131072);
        repeat (12) step();
        chk("sat_lo", longint'(y0), -131072);

        // Coefficient writes mid-stream, including an out-of-range address
        do_reset();
        in_valid = 1'b1; x_in = '0;
        repeat (3) step();
        wr(0, 1, 0);
        wr(1, 3, 0);
        step();
        step();
        run_imp(0, 0, 0, 11, 0);
        exp_q = '{0, 0, 9666, 16384, 9666, 0, 0, 0, 0, 0, 0};
        cmp_seq("cw", cap0);
        exp_q = '{-375, 0, 2500, 0, 8750, 16384, 8750, 0, 2500, 0, -375};
        cmp_seq("cw_k3", cap1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x_in = 18'($urandom);
            if ($urandom_range(0, 15) == 0) decim_en = ~decim_en;
            if ($urandom_range(0, 9) == 0) wr(0, $urandom_range(0, 1), $urandom);
            if ($urandom_range(0, 9) == 0) wr(1, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 7) == 0) wd = 18'($urandom_range(0, 20000));
            step();
        end

        // Asynchronous reset during an impulse response
        decim_en = 1'b0;
        do_reset();
        wr(0, 1, 0); step();
        in_valid = 1'b1; x_in = 18'sd65536;
        step();
        x_in = '0;
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check();
        chk("rst_y", longint'(y0), 0);
        chk("rst_ov", longint'(ov0), 0);
        @(posedge clk);
        #1;
        check();
        reset = 1'b1;
        in_valid = 1'b1; x_in = '0;
        repeat (4) step();
        run_imp(0, 0, 0, 8, 0);
        exp_q = '{-1617, 0, 9666, 16384, 9666, 0, -1617, 0};
        cmp_seq("rst_imp", cap0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
